// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-read-port register file with write bypass and busy scoreboard
// Decode-stage operand storage: combinational reads, writeback port, issue-driven pending bits.
module regfile_mp_sb #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NRD*AW-1:0]    rd_addr_i,
  output logic [NRD*WIDTH-1:0] rd_data_o,
  output logic [NRD-1:0]       rd_busy_o,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic                 iss_en_i,
  input  logic [AW-1:0]        iss_addr_i,
  output logic [AW:0]          busy_cnt_o
);

  localparam logic [AW-1:0] ZADDR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             wr_ok, iss_ok, cnt_inc, cnt_dec;

  // The zero register swallows both writebacks and issues.
  assign wr_ok  = wr_en_i  && !((ZERO_REG != 0) && (wr_addr_i  == ZADDR));
  assign iss_ok = iss_en_i && !((ZERO_REG != 0) && (iss_addr_i == ZADDR));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[wr_addr_i]  = 1'b0;
    if (iss_ok) busy_d[iss_addr_i] = 1'b1;
  end

  // Only one issue and one writeback per cycle, so the count moves by at most one each way.
  assign cnt_inc = iss_ok && !busy_q[iss_addr_i];
  assign cnt_dec = wr_ok && busy_q[wr_addr_i] && !(iss_ok && (iss_addr_i == wr_addr_i));

  always_comb begin
    cnt_d = cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt_o = cnt_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]    addr;
    logic             is_zero, fwd;
    logic [WIDTH-1:0] data;
    logic             busy;

    assign addr    = rd_addr_i[p*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (addr == ZADDR);
    assign fwd     = (BYPASS != 0) && wr_en_i && (wr_addr_i == addr);

    // A same-cycle issue to the forwarded register names a new producer, so busy stays set.
    always_comb begin
      data = mem_q[addr];
      busy = busy_q[addr];
      if (fwd) begin
        data = wr_data_i;
        busy = iss_en_i && (iss_addr_i == addr);
      end
      if (is_zero) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data_o[p*WIDTH +: WIDTH] = data;
    assign rd_busy_o[p]                = busy;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - directed and model-based checks for regfile_mp_sb
module tb_regfile_mp_sb;
  localparam int WIDTH = 64;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*WIDTH-1:0] rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [WIDTH-1:0]     wr_data;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;
  logic [AW:0]          busy_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] rd0, rd1;
  assign rd0 = rd_data[WIDTH-1:0];
  assign rd1 = rd_data[2*WIDTH-1:WIDTH];

  regfile_mp_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .iss_en_i(iss_en),
    .iss_addr_i(iss_addr), .busy_cnt_o(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
                       input logic ie, input logic [AW-1:0] ia,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; iss_en = ie; iss_addr = ia;
    rd_addr = {r1, r0};
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, 5'd3, 64'h55, 1'b1, 5'd4, 5'd3, 5'd4);
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    n_vec++;
    if (rd0 !== 64'h55) begin n_err++; $display("FAIL reset_pre_data got %h want %h", rd0, 64'h55); end
    n_vec++;
    if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL reset_pre_cnt got %0d want 1", busy_cnt); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (rd_data !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", rd_data); end
    n_vec++;
    if (rd_busy !== 2'b00) begin n_err++; $display("FAIL reset_busy got %b want 00", rd_busy); end
    n_vec++;
    if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", busy_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    drive(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    n_vec++;
    if (rd0 !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL wr_rd_p0 got %h want deadbeef", rd0); end
    n_vec++;
    if (rd1 !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL wr_rd_p1 got %h want deadbeef", rd1); end
  endtask

  task automatic test_bypass;
    drive(1'b1, 5'd7, 64'h1111, 1'b1, 5'd7, 5'd0, 5'd0);
    drive(1'b1, 5'd7, 64'h1234, 1'b0, 5'd0, 5'd7, 5'd6);
    n_vec++;
    if (rd0 !== 64'h1234) begin n_err++; $display("FAIL byp_data got %h want 1234", rd0); end
    n_vec++;
    if (rd1 !== 64'h0) begin n_err++; $display("FAIL byp_other got %h want 0", rd1); end
    n_vec++;
    if (rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL byp_busy_clr got %b want 0", rd_busy[0]); end
    n_vec++;
    if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL byp_cnt_old got %0d want 1", busy_cnt); end
    drive(1'b1, 5'd7, 64'h5678, 1'b1, 5'd7, 5'd7, 5'd7);
    n_vec++;
    if (rd_busy !== 2'b11) begin n_err++; $display("FAIL byp_new_prod got %b want 11", rd_busy); end
    n_vec++;
    if (rd1 !== 64'h5678) begin n_err++; $display("FAIL byp_p1 got %h want 5678", rd1); end
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    n_vec++;
    if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL byp_cnt_reissue got %0d want 1", busy_cnt); end
    drive(1'b1, 5'd7, 64'h5678, 1'b0, 5'd0, 5'd7, 5'd7);
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    n_vec++;
    if (busy_cnt !== 6'd0 || rd_busy !== 2'b00) begin
      n_err++; $display("FAIL byp_drain cnt %0d busy %b want 0 00", busy_cnt, rd_busy);
    end
  endtask

  task automatic test_zero_reg;
    drive(1'b1, 5'd31, 64'hFFFF, 1'b0, 5'd0, 5'd31, 5'd31);
    n_vec++;
    if (rd_data !== '0) begin n_err++; $display("FAIL zero_bypass got %h want 0", rd_data); end
    drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd31, 5'd31, 5'd31);
    n_vec++;
    if (rd0 !== 64'h0) begin n_err++; $display("FAIL zero_read got %h want 0", rd0); end
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd31, 5'd31);
    n_vec++;
    if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL zero_cnt got %0d want 0", busy_cnt); end
    n_vec++;
    if (rd_busy !== 2'b00) begin n_err++; $display("FAIL zero_busy got %b want 00", rd_busy); end
  endtask

  task automatic test_scoreboard;
    drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd2, 5'd2, 5'd2);
    drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd2, 5'd2, 5'd2);
    n_vec++;
    if (rd_busy !== 2'b11 || busy_cnt !== 6'd1) begin
      n_err++; $display("FAIL sb_issue busy %b cnt %0d want 11 1", rd_busy, busy_cnt);
    end
    drive(1'b1, 5'd2, 64'hAB, 1'b1, 5'd2, 5'd2, 5'd2);
    n_vec++;
    if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL sb_reissue_cnt got %0d want 1", busy_cnt); end
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd2, 5'd2);
    n_vec++;
    if (rd_busy !== 2'b11 || busy_cnt !== 6'd1) begin
      n_err++; $display("FAIL sb_iss_wb busy %b cnt %0d want 11 1", rd_busy, busy_cnt);
    end
    drive(1'b1, 5'd2, 64'hCD, 1'b0, 5'd0, 5'd2, 5'd9);
    drive(1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 5'd2, 5'd9);
    n_vec++;
    if (rd_busy !== 2'b00 || busy_cnt !== 6'd0) begin
      n_err++; $display("FAIL sb_wb busy %b cnt %0d want 00 0", rd_busy, busy_cnt);
    end
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd2, 5'd9);
    n_vec++;
    if (busy_cnt !== 6'd0 || rd0 !== 64'hCD || rd1 !== 64'h99) begin
      n_err++; $display("FAIL sb_wb_idle cnt %0d r2 %h r9 %h want 0 cd 99", busy_cnt, rd0, rd1);
    end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] m_mem [DEPTH];
    logic             m_busy [DEPTH];
    int               m_cnt;
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] exp_d;
    logic             exp_b;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int r = 0; r < DEPTH; r++) begin m_mem[r] = '0; m_busy[r] = 1'b0; end
    m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_addr  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wr_data  = {$urandom, $urandom};
      iss_en   = ($urandom_range(0, 3) != 0);
      iss_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      for (int p = 0; p < NRD; p++)
        rd_addr[p*AW +: AW] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      #1;
      for (int p = 0; p < NRD; p++) begin
        a = rd_addr[p*AW +: AW];
        if (a == 5'd31) begin
          exp_d = '0; exp_b = 1'b0;
        end else if (wr_en && wr_addr == a) begin
          exp_d = wr_data; exp_b = iss_en && (iss_addr == a);
        end else begin
          exp_d = m_mem[a]; exp_b = m_busy[a];
        end
        n_vec++;
        if (rd_data[p*WIDTH +: WIDTH] !== exp_d || rd_busy[p] !== exp_b) begin
          n_err++;
          $display("FAIL rnd_rd c%0d p%0d a%0d got %h/%b want %h/%b", c, p, a,
                   rd_data[p*WIDTH +: WIDTH], rd_busy[p], exp_d, exp_b);
        end
      end
      n_vec++;
      if (busy_cnt !== 6'(m_cnt)) begin
        n_err++; $display("FAIL rnd_cnt c%0d got %0d want %0d", c, busy_cnt, m_cnt);
      end
      @(posedge clk);
      if (wr_en && wr_addr != 5'd31) m_mem[wr_addr] = wr_data;
      for (int r = 0; r < DEPTH - 1; r++) begin
        if (iss_en && iss_addr == 5'(r))     m_busy[r] = 1'b1;
        else if (wr_en && wr_addr == 5'(r))  m_busy[r] = 1'b0;
      end
      m_cnt = 0;
      for (int r = 0; r < DEPTH; r++) m_cnt += int'(m_busy[r]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
